beamform_sequencer: RTL and testbench

Central controller for the 8-channel delay-and-sum beamformer. It sequences one capture frame through four phases. First it streams the shared signal BRAM into the channel filters and fill counters. Then it steps the per-channel delay beamformers through their slice schedule, and finally it reads back and sums the channel outputs, presenting each summed word through a valid/ready handshake to the UART framer. It sits between the PLL lock indication and the eight channel datapaths, replacing ad-hoc sequencing in the top level.

---
 rtl/beamform_pkg.sv | 36 +++
 rtl/beamform_slice_ctr.sv | 43 ++++
 rtl/beamform_sequencer.sv | 228 ++++++++++++++++++++++
 tb/tb_beamform_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/beamform_pkg.sv
// beamform_pkg: shared types and widths for the beamformer frame sequencer.
package beamform_pkg;

  localparam int SIG_AW  = 11;  // signal / channel input BRAM address width
  localparam int OUT_AW  = 10;  // channel output BRAM address width
  localparam int IDX_W   = 16;  // output sample index width
  localparam int PAIR_W  = 34;  // stage-1 pair sum width (adders live outside)
  localparam int TOTAL_W = 40;  // stage-2 total width (adders live outside)

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FILTER   = 3'd1,
    S_DRAIN    = 3'd2,
    S_BEAMFORM = 3'd3,
    S_SUM      = 3'd4,
    S_DONE     = 3'd5
  } seq_state_t;

  typedef enum logic [1:0] {
    SUB_ADDR = 2'd0,
    SUB_CAP1 = 2'd1,
    SUB_CAP2 = 2'd2,
    SUB_OUT  = 2'd3
  } sum_sub_t;

  // States in which losing PLL lock abandons the frame.
  function automatic logic is_abortable(input seq_state_t st);
    logic r;
    case (st)
      S_FILTER, S_DRAIN, S_BEAMFORM, S_SUM: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/beamform_slice_ctr.sv
// beamform_slice_ctr: slice round-robin and output sample index stepping
// used while the channel beamformers run.
module beamform_slice_ctr
  import beamform_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,        // back to frame-start values
  input  logic             park,       // leave BEAMFORM: slice to 0, index held
  input  logic             step,       // one BEAMFORM cycle elapsed
  output logic [1:0]       slice_state,
  output logic [IDX_W-1:0] sample_index,
  output logic             addr_step   // readin_addr advances this cycle
);

  // The input address advances once per round, on the slice-3 cycle.
  always_comb begin
    if (step && (slice_state == 2'd3)) begin
      addr_step = 1'b1;
    end else begin
      addr_step = 1'b0;
    end
  end

  // Slice rotation 0..3; the index moves on slices 1..3 and wraps freely.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slice_state  <= 2'd0;
      sample_index <= {IDX_W{1'b1}};
    end else if (clr) begin
      slice_state  <= 2'd0;
      sample_index <= {IDX_W{1'b1}};
    end else if (park) begin
      slice_state  <= 2'd0;
    end else if (step) begin
      slice_state <= slice_state + 2'd1;
      if (slice_state != 2'd0) begin
        sample_index <= sample_index + IDX_W'(1);
      end
    end
  end

endmodule

// File: rtl/beamform_sequencer.sv
// beamform_sequencer: frame controller for the 8-channel delay-and-sum
// beamformer. Streams the signal BRAM through the channel filters, runs the
// beamformer slice schedule, then reads back and hands out summed words.
module beamform_sequencer
  import beamform_pkg::*;
#(
  parameter int SIG_DEPTH  = 2048,
  parameter int FILTER_LAT = 8,
  parameter int OUT_DEPTH  = 540
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              locked,
  input  logic              bf_done,
  input  logic              sum_ready,
  output logic              signal_rden,
  output logic [SIG_AW-1:0] signal_addr,
  output logic              chan_rst,
  output logic              chan_start,
  output logic              wr_valid,
  output logic [SIG_AW-1:0] readin_addr,
  output logic              bf_start,
  output logic              out_read_en,
  output logic [1:0]        slice_state,
  output logic [IDX_W-1:0]  sample_index,
  output logic              sumout_en,
  output logic [OUT_AW-1:0] sumout_addr,
  output logic              pair_en,
  output logic              total_en,
  output logic              sum_valid,
  output logic              busy,
  output logic              done
);

  localparam int                FILL_W     = $clog2(FILTER_LAT + 1);
  localparam logic [SIG_AW-1:0] SIG_LAST   = SIG_AW'(SIG_DEPTH - 1);
  localparam logic [OUT_AW-1:0] OUT_LAST   = OUT_AW'(OUT_DEPTH - 1);
  localparam logic [FILL_W-1:0] FILL_SAT   = FILL_W'(FILTER_LAT);
  localparam logic [FILL_W-1:0] DRAIN_LAST = FILL_W'(FILTER_LAT - 1);

  seq_state_t        state_r;
  sum_sub_t          sub_r;
  logic [FILL_W-1:0] fill_r;       // filter fill count, reused as drain count
  logic [FILL_W-1:0] fill_next_s;
  logic              abort_s;
  logic              bf_step_s;
  logic              bf_park_s;
  logic              ctr_clr_s;
  logic              addr_step_s;

  // Decode abort, slice-counter controls and the saturating fill count.
  always_comb begin
    abort_s   = is_abortable(state_r) && !locked;
    bf_step_s = 1'b0;
    bf_park_s = 1'b0;
    if ((state_r == S_BEAMFORM) && locked) begin
      bf_step_s = !bf_done;
      bf_park_s = bf_done;
    end else begin
      bf_step_s = 1'b0;
      bf_park_s = 1'b0;
    end
    ctr_clr_s = abort_s || (state_r == S_IDLE);
    if (fill_r == FILL_SAT) begin
      fill_next_s = fill_r;
    end else begin
      fill_next_s = fill_r + FILL_W'(1);
    end
  end

  beamform_slice_ctr u_slice_ctr (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr          (ctr_clr_s),
    .park         (bf_park_s),
    .step         (bf_step_s),
    .slice_state  (slice_state),
    .sample_index (sample_index),
    .addr_step    (addr_step_s)
  );

  // Frame state machine with all sequencing outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= S_IDLE;
      sub_r       <= SUB_ADDR;
      fill_r      <= {FILL_W{1'b0}};
      signal_rden <= 1'b0;
      signal_addr <= {SIG_AW{1'b0}};
      chan_rst    <= 1'b0;
      chan_start  <= 1'b0;
      wr_valid    <= 1'b0;
      readin_addr <= {SIG_AW{1'b0}};
      bf_start    <= 1'b0;
      out_read_en <= 1'b0;
      sumout_en   <= 1'b0;
      sumout_addr <= {OUT_AW{1'b0}};
      pair_en     <= 1'b0;
      total_en    <= 1'b0;
      sum_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else if (abort_s) begin
      // Lost lock: everything back to its idle value, frame not completed.
      state_r     <= S_IDLE;
      sub_r       <= SUB_ADDR;
      fill_r      <= {FILL_W{1'b0}};
      signal_rden <= 1'b0;
      signal_addr <= {SIG_AW{1'b0}};
      chan_rst    <= 1'b0;
      chan_start  <= 1'b0;
      wr_valid    <= 1'b0;
      readin_addr <= {SIG_AW{1'b0}};
      bf_start    <= 1'b0;
      out_read_en <= 1'b0;
      sumout_en   <= 1'b0;
      sumout_addr <= {OUT_AW{1'b0}};
      pair_en     <= 1'b0;
      total_en    <= 1'b0;
      sum_valid   <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (locked) begin
            state_r     <= S_FILTER;
            signal_rden <= 1'b1;
            signal_addr <= {SIG_AW{1'b0}};
            chan_rst    <= 1'b1;
            chan_start  <= 1'b1;
            fill_r      <= {FILL_W{1'b0}};
            busy        <= 1'b1;
          end
        end
        S_FILTER: begin
          fill_r   <= fill_next_s;
          wr_valid <= (fill_next_s == FILL_SAT);
          if (wr_valid) begin
            readin_addr <= readin_addr + SIG_AW'(1);
          end
          if (signal_addr == SIG_LAST) begin
            // Last read issued; the filter pipeline still holds FILTER_LAT samples.
            state_r     <= S_DRAIN;
            signal_rden <= 1'b0;
            signal_addr <= {SIG_AW{1'b0}};
            fill_r      <= {FILL_W{1'b0}};
            wr_valid    <= 1'b1;
          end else begin
            signal_addr <= signal_addr + SIG_AW'(1);
          end
        end
        S_DRAIN: begin
          readin_addr <= readin_addr + SIG_AW'(1);
          if (fill_r == DRAIN_LAST) begin
            state_r     <= S_BEAMFORM;
            readin_addr <= {SIG_AW{1'b0}};
            wr_valid    <= 1'b0;
            chan_rst    <= 1'b0;
            chan_start  <= 1'b0;
            bf_start    <= 1'b1;
            out_read_en <= 1'b1;
            fill_r      <= {FILL_W{1'b0}};
          end else begin
            fill_r <= fill_r + FILL_W'(1);
          end
        end
        S_BEAMFORM: begin
          if (bf_done) begin
            state_r     <= S_SUM;
            sub_r       <= SUB_ADDR;
            bf_start    <= 1'b0;
            out_read_en <= 1'b0;
            sumout_en   <= 1'b1;
            sumout_addr <= {OUT_AW{1'b0}};
          end else if (addr_step_s) begin
            readin_addr <= readin_addr + SIG_AW'(1);
          end
        end
        S_SUM: begin
          case (sub_r)
            SUB_ADDR: begin
              // Address was presented this cycle; data is valid next cycle.
              sub_r   <= SUB_CAP1;
              pair_en <= 1'b1;
            end
            SUB_CAP1: begin
              sub_r    <= SUB_CAP2;
              pair_en  <= 1'b0;
              total_en <= 1'b1;
            end
            SUB_CAP2: begin
              sub_r     <= SUB_OUT;
              total_en  <= 1'b0;
              sum_valid <= 1'b1;
            end
            SUB_OUT: begin
              if (sum_ready) begin
                sum_valid <= 1'b0;
                sub_r     <= SUB_ADDR;
                if (sumout_addr == OUT_LAST) begin
                  state_r     <= S_DONE;
                  sumout_addr <= {OUT_AW{1'b0}};
                  sumout_en   <= 1'b0;
                  busy        <= 1'b0;
                  done        <= 1'b1;
                end else begin
                  sumout_addr <= sumout_addr + OUT_AW'(1);
                end
              end
            end
            default: begin
              sub_r <= SUB_ADDR;
            end
          endcase
        end
        S_DONE: begin
          // Sticky until reset.
          done <= 1'b1;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_beamform_sequencer.sv
// tb_beamform_sequencer: scoreboard bench. Stimulus pushes expected writes,
// beamform steps and summed-word addresses; a monitor pops and compares.
`timescale 1ns/1ps
module tb_beamform_sequencer;

  localparam int SIG_DEPTH  = 2048;
  localparam int FILTER_LAT = 8;
  localparam int OUT_DEPTH  = 540;

  logic        clk = 1'b0;
  logic        rst_n, locked, bf_done, sum_ready;
  logic        signal_rden, chan_rst, chan_start, wr_valid, bf_start, out_read_en;
  logic [10:0] signal_addr, readin_addr;
  logic [1:0]  slice_state;
  logic [15:0] sample_index;
  logic        sumout_en, pair_en, total_en, sum_valid, busy, done;
  logic [9:0]  sumout_addr;

  beamform_sequencer #(
    .SIG_DEPTH(SIG_DEPTH), .FILTER_LAT(FILTER_LAT), .OUT_DEPTH(OUT_DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .locked(locked), .bf_done(bf_done),
    .sum_ready(sum_ready), .signal_rden(signal_rden), .signal_addr(signal_addr),
    .chan_rst(chan_rst), .chan_start(chan_start), .wr_valid(wr_valid),
    .readin_addr(readin_addr), .bf_start(bf_start), .out_read_en(out_read_en),
    .slice_state(slice_state), .sample_index(sample_index), .sumout_en(sumout_en),
    .sumout_addr(sumout_addr), .pair_en(pair_en), .total_en(total_en),
    .sum_valid(sum_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  slice;
    logic [15:0] idx;
    logic [10:0] raddr;
  } bf_exp_t;

  int unsigned wq[$];   // expected readin_addr per filtered write
  bf_exp_t     bq[$];   // expected outputs per BEAMFORM cycle
  logic [15:0] iq[$];   // expected sample_index on SUM entry
  int unsigned sq[$];   // expected sumout_addr per accepted word

  int n_vec = 0;
  int n_err = 0;
  int stall_word = -1;
  bit stall_done = 1'b0;
  bit rand_ready = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: after s stepping cycles, slices 1..3 of each 4-cycle
  // round have each advanced the index, and every completed slice 3 the address.
  function automatic logic [15:0] idx_after(input int s);
    int adv;
    adv = s - (s + 3) / 4;
    return 16'hFFFF + 16'(adv);
  endfunction

  function automatic logic [10:0] raddr_after(input int s);
    return 11'(s / 4);
  endfunction

  task automatic push_writes();
    for (int i = 0; i < SIG_DEPTH; i++) wq.push_back(i);
  endtask

  task automatic push_bf(input int ncyc);
    bf_exp_t b;
    for (int i = 0; i < ncyc; i++) begin
      b.slice = 2'(i % 4);
      b.idx   = idx_after(i);
      b.raddr = raddr_after(i);
      bq.push_back(b);
    end
  endtask

  task automatic push_sums();
    for (int i = 0; i < OUT_DEPTH; i++) sq.push_back(i);
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".signal_rden"},  signal_rden, 0);
    check({tag, ".signal_addr"},  signal_addr, 0);
    check({tag, ".chan_rst"},     chan_rst, 0);
    check({tag, ".chan_start"},   chan_start, 0);
    check({tag, ".wr_valid"},     wr_valid, 0);
    check({tag, ".readin_addr"},  readin_addr, 0);
    check({tag, ".bf_start"},     bf_start, 0);
    check({tag, ".out_read_en"},  out_read_en, 0);
    check({tag, ".slice_state"},  slice_state, 0);
    check({tag, ".sample_index"}, sample_index, 32'hFFFF);
    check({tag, ".sumout_en"},    sumout_en, 0);
    check({tag, ".sumout_addr"},  sumout_addr, 0);
    check({tag, ".pair_en"},      pair_en, 0);
    check({tag, ".total_en"},     total_en, 0);
    check({tag, ".sum_valid"},    sum_valid, 0);
    check({tag, ".busy"},         busy, 0);
    check({tag, ".done"},         done, 0);
  endtask

  // Wait for BEAMFORM, then raise bf_done in cycle ncyc-1 of it.
  task automatic run_beamform(input int ncyc);
    for (int i = 0; i < 5000 && !bf_start; i++) @(negedge clk);
    check("bf_enter", bf_start, 1);
    repeat (ncyc - 1) @(negedge clk);
    bf_done = 1'b1;
    @(negedge clk);
    bf_done = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
    check("done_seen", done, 1);
    check("done_busy", busy, 0);
    check("wq_empty", wq.size(), 0);
    check("bq_empty", bq.size(), 0);
    check("sq_empty", sq.size(), 0);
    check("iq_empty", iq.size(), 0);
  endtask

  // Consumer: optional fixed 10-cycle stall on one word, else ready high or random.
  initial begin : ready_drv
    sum_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (stall_word >= 0 && !stall_done && sum_valid && sumout_addr == 10'(stall_word)) begin
        sum_ready = 1'b0;
        repeat (10) @(negedge clk);
        sum_ready  = 1'b1;
        stall_done = 1'b1;
      end else if (rand_ready) begin
        sum_ready = ($urandom_range(0, 2) != 0);
      end else begin
        sum_ready = 1'b1;
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents an output.
  initial begin : monitor
    int          cyc, last_acc, low_cnt, pe_cnt, te_cnt;
    bit          prev_en, prev_valid, prev_acc, exp_done;
    logic [9:0]  prev_addr;
    int unsigned we, se;
    bf_exp_t     b;
    cyc = 0; last_acc = 0; low_cnt = 0; pe_cnt = 0; te_cnt = 0;
    prev_en = 0; prev_valid = 0; prev_acc = 0; exp_done = 0; prev_addr = 10'd0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      if (exp_done) begin
        check("done_flag", done, 1);
        check("done_busy_now", busy, 0);
        check("done_saddr", sumout_addr, 0);
        check("done_sumout_en", sumout_en, 0);
        check("done_valid", sum_valid, 0);
        exp_done = 1'b0;
      end
      if (wr_valid) begin
        if (wq.size() == 0) begin
          check("wr_extra", 1, 0);
        end else begin
          we = wq.pop_front();
          check("wr_readin_addr", readin_addr, we);
          check("wr_chan_rst", chan_rst, 1);
          if (we < SIG_DEPTH - FILTER_LAT) begin
            check("filt_rden", signal_rden, 1);
            check("filt_sigaddr", signal_addr, we + FILTER_LAT);
          end else begin
            check("drain_rden", signal_rden, 0);
          end
        end
      end
      if (bf_start) begin
        if (bq.size() == 0) begin
          check("bf_extra", 1, 0);
        end else begin
          b = bq.pop_front();
          check("bf_slice", slice_state, b.slice);
          check("bf_idx", sample_index, b.idx);
          check("bf_raddr", readin_addr, b.raddr);
          check("bf_out_read_en", out_read_en, 1);
          check("bf_chan_rst", chan_rst, 0);
        end
      end
      if (sumout_en && !prev_en) begin
        if (iq.size() == 0) check("sum_entry_extra", 1, 0);
        else check("entry_idx", sample_index, iq.pop_front());
        check("entry_slice", slice_state, 0);
        check("entry_saddr", sumout_addr, 0);
        check("entry_bf_start", bf_start, 0);
        check("entry_out_read_en", out_read_en, 0);
        last_acc = cyc - 1; low_cnt = 0; pe_cnt = 0; te_cnt = 0;
      end
      if (pair_en)  pe_cnt++;
      if (total_en) te_cnt++;
      if (sum_valid && prev_valid && !prev_acc) check("hold_addr", sumout_addr, prev_addr);
      if (sum_valid && !sum_ready) low_cnt++;
      prev_acc = 1'b0;
      if (sum_valid && sum_ready) begin
        if (sq.size() == 0) begin
          check("sum_extra", 1, 0);
        end else begin
          se = sq.pop_front();
          check("sum_addr", sumout_addr, se);
          check("word_period", cyc - last_acc, 4 + low_cnt);
          check("pair_pulses", pe_cnt, 1);
          check("total_pulses", te_cnt, 1);
          if (stall_word >= 0 && se == stall_word) check("stall_len", low_cnt, 10);
          if (se == OUT_DEPTH - 1) exp_done = 1'b1;
        end
        last_acc = cyc; low_cnt = 0; pe_cnt = 0; te_cnt = 0; prev_acc = 1'b1;
      end
      prev_en = sumout_en; prev_valid = sum_valid; prev_addr = sumout_addr;
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not complete, got %0d vectors expected completion", n_vec);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n, m;
    rst_n = 1'b0; locked = 1'b1; bf_done = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("reset");

    // Frame A: locked through reset, bf_done lands in slice 2, word 5 stalled.
    push_writes();
    n = 4 * $urandom_range(2, 6) + 3;
    push_bf(n);
    iq.push_back(idx_after(n - 1));
    push_sums();
    stall_word = 5; stall_done = 1'b0; rand_ready = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("a_start_rden", signal_rden, 1);
    check("a_start_sigaddr", signal_addr, 0);
    check("a_start_busy", busy, 1);
    check("a_start_wr_valid", wr_valid, 0);
    run_beamform(n);
    wait_done();
    repeat (3) @(negedge clk);
    check("a_done_sticky", done, 1);

    // Frame B: abort mid-BEAMFORM by dropping lock.
    rst_n = 1'b0; locked = 1'b0; stall_word = -1;
    @(negedge clk);
    check_reset("reset2");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset("idle_unlocked");
    push_writes();
    m = $urandom_range(3, 20);
    push_bf(m + 1);
    locked = 1'b1;
    for (int i = 0; i < 5000 && !bf_start; i++) @(negedge clk);
    check("b_bf_enter", bf_start, 1);
    repeat (m) @(negedge clk);
    locked = 1'b0;
    @(negedge clk);
    check_reset("abort");
    check("abort_wq_empty", wq.size(), 0);
    check("abort_bq_empty", bq.size(), 0);
    repeat (2) @(negedge clk);

    // Frame C: restart after abort, random bf_done point and random backpressure.
    push_writes();
    n = $urandom_range(1, 30);
    push_bf(n);
    iq.push_back(idx_after(n - 1));
    push_sums();
    rand_ready = 1'b1;
    locked = 1'b1;
    @(negedge clk);
    check("c_restart_rden", signal_rden, 1);
    check("c_restart_sigaddr", signal_addr, 0);
    run_beamform(n);
    wait_done();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
